// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: operand/control latch, EX/MEM and MEM/WB forwarding,
// immediate/shift operand select and load-use bubble insertion. Optional STALL_CNT_EN adds stall_count.
module id_ex_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int REG_ADDR_W    = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     id_valid,
    input  logic [REG_ADDR_W-1:0]    id_rs1_addr,
    input  logic [REG_ADDR_W-1:0]    id_rs2_addr,
    input  logic [REG_ADDR_W-1:0]    id_rd_addr,
    input  logic [DATA_WIDTH-1:0]    id_rs1_data,
    input  logic [DATA_WIDTH-1:0]    id_rs2_data,
    input  logic [DATA_WIDTH-1:0]    id_imm,
    input  logic                     id_alu_src,
    input  logic [OPCODE_LENGTH-1:0] id_alu_op,
    input  logic                     id_reg_write,
    input  logic                     id_mem_read,
    input  logic                     id_mem_write,
    input  logic                     id_mem_to_reg,
    input  logic                     stall,
    input  logic                     flush,
    input  logic [REG_ADDR_W-1:0]    exmem_rd,
    input  logic                     exmem_reg_write,
    input  logic [DATA_WIDTH-1:0]    exmem_result,
    input  logic [REG_ADDR_W-1:0]    memwb_rd,
    input  logic                     memwb_reg_write,
    input  logic [DATA_WIDTH-1:0]    memwb_result,
    output logic                     stall_req,
    output logic                     ex_valid,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic [DATA_WIDTH-1:0]    ex_store_data,
    output logic [REG_ADDR_W-1:0]    ex_rd,
    output logic                     ex_reg_write,
    output logic                     ex_mem_read,
    output logic                     ex_mem_write,
    output logic                     ex_mem_to_reg
`ifdef STALL_CNT_EN
    ,
    output logic [31:0]              stall_count
`endif
);

    localparam logic [OPCODE_LENGTH-1:0] OP_SLL = OPCODE_LENGTH'(4'b0100);
    localparam logic [OPCODE_LENGTH-1:0] OP_SRL = OPCODE_LENGTH'(4'b0101);
    localparam logic [OPCODE_LENGTH-1:0] OP_SRA = OPCODE_LENGTH'(4'b0111);

    logic                     valid_q,      valid_d;
    logic [REG_ADDR_W-1:0]    rs1_addr_q,   rs1_addr_d;
    logic [REG_ADDR_W-1:0]    rs2_addr_q,   rs2_addr_d;
    logic [REG_ADDR_W-1:0]    rd_q,         rd_d;
    logic [DATA_WIDTH-1:0]    rs1_data_q,   rs1_data_d;
    logic [DATA_WIDTH-1:0]    rs2_data_q,   rs2_data_d;
    logic [DATA_WIDTH-1:0]    imm_q,        imm_d;
    logic                     alu_src_q,    alu_src_d;
    logic [OPCODE_LENGTH-1:0] alu_op_q,     alu_op_d;
    logic                     reg_write_q,  reg_write_d;
    logic                     mem_read_q,   mem_read_d;
    logic                     mem_write_q,  mem_write_d;
    logic                     mem_to_reg_q, mem_to_reg_d;

    logic [DATA_WIDTH-1:0]    fwd_rs1;
    logic [DATA_WIDTH-1:0]    fwd_rs2;
    logic [DATA_WIDTH-1:0]    shift_b;
    logic                     is_shift_imm;

    assign ex_valid      = valid_q;
    assign ex_rd         = rd_q;
    assign Operation     = alu_op_q;
    assign ex_reg_write  = reg_write_q  & valid_q;
    assign ex_mem_read   = mem_read_q   & valid_q;
    assign ex_mem_write  = mem_write_q  & valid_q;
    assign ex_mem_to_reg = mem_to_reg_q & valid_q;

    // A load in EX cannot forward in time to a dependent instruction in decode.
    assign stall_req = ex_valid & ex_mem_read & (ex_rd != '0) & id_valid &
                       ((ex_rd == id_rs1_addr) | ((ex_rd == id_rs2_addr) & ~id_alu_src));

    always_comb begin
        fwd_rs1 = rs1_data_q;
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs1_addr_q)) begin
            fwd_rs1 = exmem_result;
        end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs1_addr_q)) begin
            fwd_rs1 = memwb_result;
        end
    end

    always_comb begin
        fwd_rs2 = rs2_data_q;
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs2_addr_q)) begin
            fwd_rs2 = exmem_result;
        end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs2_addr_q)) begin
            fwd_rs2 = memwb_result;
        end
    end

    // The ALU reads immediate shift amounts from SrcB[24:20].
    always_comb begin
        shift_b        = '0;
        shift_b[24:20] = imm_q[4:0];
    end

    assign is_shift_imm = (alu_op_q == OP_SLL) | (alu_op_q == OP_SRL) | (alu_op_q == OP_SRA);

    always_comb begin
        SrcA = fwd_rs1;
        if (!alu_src_q) begin
            SrcB = fwd_rs2;
        end else if (is_shift_imm) begin
            SrcB = shift_b;
        end else begin
            SrcB = imm_q;
        end
    end

    assign ex_store_data = fwd_rs2;

    always_comb begin
        valid_d      = valid_q;
        rs1_addr_d   = rs1_addr_q;
        rs2_addr_d   = rs2_addr_q;
        rd_d         = rd_q;
        rs1_data_d   = rs1_data_q;
        rs2_data_d   = rs2_data_q;
        imm_d        = imm_q;
        alu_src_d    = alu_src_q;
        alu_op_d     = alu_op_q;
        reg_write_d  = reg_write_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_to_reg_d = mem_to_reg_q;
        if (flush) begin
            valid_d      = 1'b0;
            reg_write_d  = 1'b0;
            mem_read_d   = 1'b0;
            mem_write_d  = 1'b0;
            mem_to_reg_d = 1'b0;
        end else if (stall) begin
            valid_d = valid_q;
        end else if (stall_req) begin
            valid_d      = 1'b0;
            reg_write_d  = 1'b0;
            mem_read_d   = 1'b0;
            mem_write_d  = 1'b0;
            mem_to_reg_d = 1'b0;
            alu_op_d     = '0;
        end else begin
            valid_d      = id_valid;
            rs1_addr_d   = id_rs1_addr;
            rs2_addr_d   = id_rs2_addr;
            rd_d         = id_rd_addr;
            rs1_data_d   = id_rs1_data;
            rs2_data_d   = id_rs2_data;
            imm_d        = id_imm;
            alu_src_d    = id_alu_src;
            alu_op_d     = id_alu_op;
            reg_write_d  = id_reg_write;
            mem_read_d   = id_mem_read;
            mem_write_d  = id_mem_write;
            mem_to_reg_d = id_mem_to_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q      <= 1'b0;
            rs1_addr_q   <= '0;
            rs2_addr_q   <= '0;
            rd_q         <= '0;
            rs1_data_q   <= '0;
            rs2_data_q   <= '0;
            imm_q        <= '0;
            alu_src_q    <= 1'b0;
            alu_op_q     <= '0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            rs1_addr_q   <= rs1_addr_d;
            rs2_addr_q   <= rs2_addr_d;
            rd_q         <= rd_d;
            rs1_data_q   <= rs1_data_d;
            rs2_data_q   <= rs2_data_d;
            imm_q        <= imm_d;
            alu_src_q    <= alu_src_d;
            alu_op_q     <= alu_op_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_to_reg_q <= mem_to_reg_d;
        end
    end

`ifdef STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_req && !stall && !flush && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: vector table for forwarding/operand select,
// plus hand sequences for reset, load-use bubble, flush-over-stall and stall hold.
module tb_id_ex_stage;

    localparam logic T = 1'b1;
    localparam logic F = 1'b0;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic        id_alu_src;
    logic [3:0]  id_alu_op;
    logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        stall, flush;
    logic [4:0]  exmem_rd, memwb_rd;
    logic        exmem_reg_write, memwb_reg_write;
    logic [31:0] exmem_result, memwb_result;
    logic        stall_req, ex_valid;
    logic [31:0] SrcA, SrcB, ex_store_data;
    logic [3:0]  Operation;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
`ifdef STALL_CNT_EN
    logic [31:0] stall_count;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_alu_src(id_alu_src), .id_alu_op(id_alu_op),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .stall(stall), .flush(flush),
        .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_result(exmem_result),
        .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_result(memwb_result),
        .stall_req(stall_req), .ex_valid(ex_valid), .SrcA(SrcA), .SrcB(SrcB),
        .Operation(Operation), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg)
`ifdef STALL_CNT_EN
        , .stall_count(stall_count)
`endif
    );

    typedef struct {
        logic        valid;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2, imm;
        logic        src;
        logic [3:0]  op;
        logic        rw, mr;
        logic [4:0]  exm_rd;
        logic        exm_we;
        logic [31:0] exm_res;
        logic [4:0]  mwb_rd;
        logic        mwb_we;
        logic [31:0] mwb_res;
        logic [31:0] e_a, e_b;
        logic [3:0]  e_op;
        logic [31:0] e_st;
        logic        e_valid, e_rw;
    } vec_t;

    vec_t vecs [13];
    vec_t ld, dep, v;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t x);
        id_valid        = x.valid;
        id_rs1_addr     = x.rs1;
        id_rs2_addr     = x.rs2;
        id_rd_addr      = x.rd;
        id_rs1_data     = x.d1;
        id_rs2_data     = x.d2;
        id_imm          = x.imm;
        id_alu_src      = x.src;
        id_alu_op       = x.op;
        id_reg_write    = x.rw;
        id_mem_read     = x.mr;
        id_mem_write    = 1'b0;
        id_mem_to_reg   = x.mr;
        exmem_rd        = x.exm_rd;
        exmem_reg_write = x.exm_we;
        exmem_result    = x.exm_res;
        memwb_rd        = x.mwb_rd;
        memwb_reg_write = x.mwb_we;
        memwb_result    = x.mwb_res;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{T,5'd1,5'd2,5'd3, 32'd5,32'd7,32'd0, F,4'b0010, T,F, 5'd0,F,32'd0, 5'd0,F,32'd0,
                     32'd5,32'd7,4'b0010,32'd7,T,T};
        vecs[1]  = '{T,5'd3,5'd4,5'd9, 32'h11,32'h22,32'd0, F,4'b0010, T,F, 5'd3,T,32'hAA, 5'd3,T,32'hBB,
                     32'hAA,32'h22,4'b0010,32'h22,T,T};
        vecs[2]  = '{T,5'd3,5'd4,5'd9, 32'h11,32'h22,32'd0, F,4'b0010, T,F, 5'd3,F,32'hAA, 5'd3,T,32'hBB,
                     32'hBB,32'h22,4'b0010,32'h22,T,T};
        vecs[3]  = '{T,5'd0,5'd4,5'd9, 32'h33,32'h22,32'd0, F,4'b0010, T,F, 5'd0,T,32'hAA, 5'd0,T,32'hBB,
                     32'h33,32'h22,4'b0010,32'h22,T,T};
        vecs[4]  = '{T,5'd1,5'd6,5'd9, 32'h1,32'h2,32'd0, F,4'b0000, T,F, 5'd7,T,32'h77, 5'd6,T,32'h66,
                     32'h1,32'h66,4'b0000,32'h66,T,T};
        vecs[5]  = '{T,5'd1,5'd2,5'd9, 32'h1,32'h9,32'd3, T,4'b0100, T,F, 5'd0,F,32'd0, 5'd0,F,32'd0,
                     32'h1,32'h0030_0000,4'b0100,32'h9,T,T};
        vecs[6]  = '{T,5'd1,5'd2,5'd9, 32'h1,32'h9,32'hFFFF_FFFF, T,4'b0000, T,F, 5'd0,F,32'd0, 5'd0,F,32'd0,
                     32'h1,32'hFFFF_FFFF,4'b0000,32'h9,T,T};
        vecs[7]  = '{T,5'd1,5'd2,5'd9, 32'h1,32'h9,32'h0000_04A5, T,4'b0111, T,F, 5'd0,F,32'd0, 5'd0,F,32'd0,
                     32'h1,32'h0050_0000,4'b0111,32'h9,T,T};
        vecs[8]  = '{T,5'd1,5'd2,5'd9, 32'h1,32'h9,32'hFFFF_FFFF, T,4'b0101, T,F, 5'd0,F,32'd0, 5'd0,F,32'd0,
                     32'h1,32'h01F0_0000,4'b0101,32'h9,T,T};
        vecs[9]  = '{T,5'd1,5'd2,5'd9, 32'h1,32'h9,32'h123, T,4'b0110, T,F, 5'd0,F,32'd0, 5'd0,F,32'd0,
                     32'h1,32'h123,4'b0110,32'h9,T,T};
        vecs[10] = '{T,5'd1,5'd2,5'd9, 32'h1,32'h9,32'h3, F,4'b0100, T,F, 5'd0,F,32'd0, 5'd0,F,32'd0,
                     32'h1,32'h9,4'b0100,32'h9,T,T};
        vecs[11] = '{F,5'd1,5'd2,5'd9, 32'h1,32'h9,32'h0, F,4'b0010, T,F, 5'd0,F,32'd0, 5'd0,F,32'd0,
                     32'h1,32'h9,4'b0010,32'h9,F,F};
        vecs[12] = '{T,5'd1,5'd8,5'd9, 32'h1,32'h9,32'h44, T,4'b0000, T,F, 5'd8,T,32'h88, 5'd0,F,32'd0,
                     32'h1,32'h44,4'b0000,32'h88,T,T};
        ld  = '{T,5'd2,5'd0,5'd5, 32'h100,32'd0,32'd4, T,4'b0000, T,T, 5'd0,F,32'd0, 5'd0,F,32'd0,
                32'd0,32'd0,4'b0000,32'd0,F,F};
        dep = '{T,5'd5,5'd1,5'd6, 32'hDEAD,32'd10,32'd0, F,4'b0010, T,F, 5'd0,F,32'd0, 5'd0,F,32'd0,
                32'd0,32'd0,4'b0000,32'd0,F,F};

        // reset with busy inputs
        stall = 1'b0;
        flush = 1'b0;
        reset = 1'b1;
        apply(ld);
        tick();
        tick();
        chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_stall_req", {31'd0, stall_req}, 32'd0);
        chk("rst_srca", SrcA, 32'd0);
        chk("rst_srcb", SrcB, 32'd0);
        chk("rst_store", ex_store_data, 32'd0);
        chk("rst_op", {28'd0, Operation}, 32'd0);
        chk("rst_rd", {27'd0, ex_rd}, 32'd0);
        chk("rst_ctrl", {28'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}, 32'd0);
`ifdef STALL_CNT_EN
        chk("rst_stall_count", stall_count, 32'd0);
`endif
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            v = vecs[i];
            apply(v);
            tick();
            chk($sformatf("v%0d_srca", i), SrcA, v.e_a);
            chk($sformatf("v%0d_srcb", i), SrcB, v.e_b);
            chk($sformatf("v%0d_op", i), {28'd0, Operation}, {28'd0, v.e_op});
            chk($sformatf("v%0d_store", i), ex_store_data, v.e_st);
            chk($sformatf("v%0d_valid", i), {31'd0, ex_valid}, {31'd0, v.e_valid});
            chk($sformatf("v%0d_rw", i), {31'd0, ex_reg_write}, {31'd0, v.e_rw});
            chk($sformatf("v%0d_stall_req", i), {31'd0, stall_req}, 32'd0);
        end

        // load-use: lw x5 in EX, add x6,x5,x1 in decode
        apply(ld);
        tick();
        chk("ld_mem_read", {31'd0, ex_mem_read}, 32'd1);
        chk("ld_mem_to_reg", {31'd0, ex_mem_to_reg}, 32'd1);
        chk("ld_rd", {27'd0, ex_rd}, 32'd5);
        apply(dep);
        #1;
        chk("lu_stall_req", {31'd0, stall_req}, 32'd1);
        tick();
        chk("bub_valid", {31'd0, ex_valid}, 32'd0);
        chk("bub_ctrl", {28'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}, 32'd0);
        chk("bub_op", {28'd0, Operation}, 32'd0);
        chk("bub_stall_req", {31'd0, stall_req}, 32'd0);
        v = dep;
        v.mwb_rd = 5'd5;
        v.mwb_we = 1'b1;
        v.mwb_res = 32'h77;
        apply(v);
        tick();
        chk("lu_add_valid", {31'd0, ex_valid}, 32'd1);
        chk("lu_add_srca", SrcA, 32'h77);
        chk("lu_add_srcb", SrcB, 32'd10);
        chk("lu_add_op", {28'd0, Operation}, 32'd2);
        chk("lu_add_stall_req", {31'd0, stall_req}, 32'd0);
`ifdef STALL_CNT_EN
        chk("lu_stall_count", stall_count, 32'd1);
`endif

        // rs2 hazard only counts when rs2 is a register operand; stall beats the bubble
        apply(ld);
        tick();
        v = dep;
        v.rs1 = 5'd0;
        v.rs2 = 5'd5;
        v.src = 1'b1;
        apply(v);
        #1;
        chk("rs2_imm_no_stall", {31'd0, stall_req}, 32'd0);
        v.src = 1'b0;
        apply(v);
        #1;
        chk("rs2_reg_stall", {31'd0, stall_req}, 32'd1);
        v.valid = 1'b0;
        apply(v);
        #1;
        chk("id_invalid_no_stall", {31'd0, stall_req}, 32'd0);
        v.valid = 1'b1;
        apply(v);
        stall = 1'b1;
        tick();
        chk("stall_over_bubble_valid", {31'd0, ex_valid}, 32'd1);
        chk("stall_over_bubble_req", {31'd0, stall_req}, 32'd1);
`ifdef STALL_CNT_EN
        chk("stall_no_count", stall_count, 32'd1);
`endif
        stall = 1'b0;
        tick();
        chk("late_bubble_valid", {31'd0, ex_valid}, 32'd0);
`ifdef STALL_CNT_EN
        chk("late_bubble_count", stall_count, 32'd2);
`endif

        // flush wins over stall
        apply(vecs[0]);
        tick();
        stall = 1'b1;
        flush = 1'b1;
        tick();
        chk("flush_stall_valid", {31'd0, ex_valid}, 32'd0);
        chk("flush_stall_rw", {31'd0, ex_reg_write}, 32'd0);
        stall = 1'b0;
        flush = 1'b0;
        tick();
        stall = 1'b1;
        apply(vecs[12]);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("hold%0d_srca", c), SrcA, 32'd5);
            chk($sformatf("hold%0d_srcb", c), SrcB, 32'd7);
            chk($sformatf("hold%0d_op", c), {28'd0, Operation}, 32'd2);
            chk($sformatf("hold%0d_valid", c), {31'd0, ex_valid}, 32'd1);
        end
        stall = 1'b0;
        tick();
        chk("release_srcb", SrcB, 32'h44);

        // reset during a pending hazard
        apply(ld);
        tick();
        apply(dep);
        #1;
        chk("pre_rst_stall_req", {31'd0, stall_req}, 32'd1);
        reset = 1'b1;
        tick();
        chk("midrst_valid", {31'd0, ex_valid}, 32'd0);
        chk("midrst_stall_req", {31'd0, stall_req}, 32'd0);
        chk("midrst_srca", SrcA, 32'd0);
`ifdef STALL_CNT_EN
        chk("midrst_count", stall_count, 32'd0);
`endif
        reset = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register directly upstream of the EX-stage ALU.
- Latches decoded operands and control, resolves data forwarding from EX/MEM and MEM/WB, and selects register or immediate operands.
- Presents SrcA, SrcB and Operation to the ALU's 4-bit op encoding.
- Detects load-use hazards and requests a decode stall, inserting a bubble into EX.

Parameters:
DATA_WIDTH, 32, operand/result width
OPCODE_LENGTH, 4, ALU operation code width
REG_ADDR_W, 5, register index width

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
id_valid  in  1  decode holds a valid instruction
id_rs1_addr  in  REG_ADDR_W  source 1 index
id_rs2_addr  in  REG_ADDR_W  source 2 index
id_rd_addr  in  REG_ADDR_W  destination index
id_rs1_data  in  DATA_WIDTH  register-file read 1
id_rs2_data  in  DATA_WIDTH  register-file read 2
id_imm  in  DATA_WIDTH  sign-extended immediate
id_alu_src  in  1  1 = SrcB from immediate
id_alu_op  in  OPCODE_LENGTH  ALU operation code
id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1 each  control bits
stall  in  1  downstream freeze; hold all state
flush  in  1  squash stage contents (branch taken)
exmem_rd  in  REG_ADDR_W  EX/MEM destination
exmem_reg_write  in  1  EX/MEM writes rd
exmem_result  in  DATA_WIDTH  EX/MEM ALU result
memwb_rd  in  REG_ADDR_W  MEM/WB destination
memwb_reg_write  in  1  MEM/WB writes rd
memwb_result  in  DATA_WIDTH  MEM/WB writeback value
stall_req  out  1  load-use hazard; decode and PC must hold
ex_valid  out  1  stage holds a valid instruction
SrcA  out  DATA_WIDTH  ALU operand A
SrcB  out  DATA_WIDTH  ALU operand B
Operation  out  OPCODE_LENGTH  ALU operation code
ex_store_data  out  DATA_WIDTH  forwarded rs2 value for stores
ex_rd  out  REG_ADDR_W  destination index
ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1 each  control, gated by ex_valid

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high.
- Reset: all registered state is 0. ex_valid=0, ex_rd=0, all control bits 0, Operation=4'b0000, SrcA=SrcB=ex_store_data=0, stall_req=0.
- Update priority on each clk edge: reset > flush > stall > load-use bubble > load.
  - flush: ex_valid=0 and all control bits=0; data registers are don't-care. Flush wins over stall.
  - stall=1: every register holds its value.
  - Load-use bubble: when stall_req=1, load ex_valid=0, control bits=0, Operation=0.
  - Load: otherwise, capture all id_* inputs; ex_valid <= id_valid.
- stall_req (combinational) = ex_valid & ex_mem_read & ex_rd!=0 & id_valid & (ex_rd==id_rs1_addr | (ex_rd==id_rs2_addr & !id_alu_src)).
  - Exactly one bubble is inserted per load-use hazard.
- Forwarding (combinational, applied to registered rs1/rs2), for each source fwd_rsN:
  - If exmem_reg_write & exmem_rd!=0 & exmem_rd==rsN, use exmem_result.
  - Else if memwb_reg_write & memwb_rd!=0 & memwb_rd==rsN, use memwb_result.
  - Else use the registered register-file data.
  - EX/MEM has priority over MEM/WB.
- SrcA = fwd_rs1.
- SrcB:
  - alu_src=0: fwd_rs2.
  - alu_src=1 and Operation in {0100, 0101, 0111} (shift by immediate): imm[4:0] placed at bits [24:20], all other bits 0. The ALU takes the shift amount from SrcB[24:20].
  - alu_src=1 otherwise: imm.
- ex_store_data = fwd_rs2 always, independent of alu_src.
- Control outputs are ANDed with ex_valid. Latency ID to EX is 1 cycle.
- Reset mid-stall or mid-hazard: reset wins; stall_req drops in the same cycle because ex_valid=0.

Optional Feature:
Macro STALL_CNT_EN.
- Defined: adds output stall_count [31:0], reset 0.
  - Increments on each edge where a load-use bubble is inserted (stall_req=1, stall=0, flush=0, reset=0).
  - Saturates at 32'hFFFF_FFFF.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: reset=1 for 2 cycles → all outputs 0, stall_req=0, ex_valid=0.
- ADD with no hazards: id_rs1_data=5, id_rs2_data=7, alu_op=0010, alu_src=0 → next cycle SrcA=5, SrcB=7, Operation=0010, ex_valid=1.
- Forward priority: stage rs1=x3, exmem_rd=3 with result 0xAA, memwb_rd=3 with result 0xBB, both writes enabled → SrcA=0xAA. Drop exmem_reg_write → SrcA=0xBB. Set rs1=x0 → SrcA is the registered data, no forwarding.
- SLLI imm=3, alu_src=1, alu_op=0100 → SrcB=32'h0030_0000. ADDI imm=-1 → SrcB=32'hFFFF_FFFF.
- Load-use: stage holds lw x5 (mem_read=1), decode add x6,x5,x1 → stall_req=1. Next cycle ex_valid=0 with controls 0. The add enters the following cycle, with the load result forwarded from MEM/WB. With STALL_CNT_EN, stall_count=1.
- Flush during stall: stall=1 and flush=1 on the same edge → ex_valid=0 and ex_reg_write=0. Stall alone holds SrcA/SrcB/Operation unchanged for 3 cycles.
